tdc_stream_tx: RTL and testbench
================================

# tdc_stream_tx

Transmit side of the histogram-builder input stream. Accepts one pixel's worth of TDC timestamps at a time from the SPAD/TDC capture logic. Serializes them onto the `wrEn`/`data` interface in the exact order the histogram builder counts: sample, then pixel, then acquisition. It tracks frame boundaries, toggles the coarse/fine pass flag per frame, and inserts an idle gap between frames so the builder's internal re-arm pipeline completes.

## Interface
Parameters:
- `NP`, 16 — timestamp width (Np).
- `DATA_NUM`, 4 — samples per pixel per acquisition, ≥2.
- `PIXEL_NUM`, 200 — pixels per RAM.
- `ACQ_NUM`, 33333 — acquisitions per frame.
- `IDLE_GAP`, 4 — wrEn-low cycles forced after each frame, ≥1.

Ports. One clock; reset is synchronous and active-high (`res`).
- `clk` in 1 — clock.
- `res` in 1 — synchronous active-high reset.
- `pix_valid` in 1 — upstream pixel word valid.
- `pix_ready` out 1 — block can accept a pixel word.
- `pix_data` in DATA_NUM*NP — samples; sample k at `[k*NP +: NP]`, sent k=0 first.
- `pix_hit` in DATA_NUM — bit k=1 means sample k is a real hit.
- `wrEn` out 1 — output sample strobe.
- `data` out NP — output timestamp.
- `pass` out 1 — 0 = coarse frame, 1 = fine frame; constant within a frame.
- `frame_done` out 1 — one-cycle pulse at frame end.
- `busy` out 1 — buffer non-empty or SEND/GAP active.

## Operation
- Input buffer: 2-entry FIFO of {pix_data, pix_hit}.
  - `pix_ready` = FIFO not full.
  - A word is accepted on `pix_valid && pix_ready`.
  - Simultaneous pop and push when the FIFO is full is not allowed; `pix_ready` is based on the registered count.
- FSM states: IDLE, SEND, GAP.
  - IDLE → SEND when the FIFO is non-empty. The head entry is popped into the shift register.
  - SEND emits one sample per cycle with `wrEn`=1, sample counter 0..DATA_NUM-1.
  - On the last sample, if the frame is not ending, the next pixel loads with no bubble if the FIFO is non-empty; otherwise → IDLE.
  - A frame ends when the last sample of pixel PIXEL_NUM-1 in acquisition ACQ_NUM-1 is sent. FSM → GAP.
  - GAP holds `wrEn`=0 for IDLE_GAP cycles, then → IDLE (or straight to SEND if the FIFO is non-empty). The FIFO keeps accepting during GAP.
- A pixel's DATA_NUM samples are always contiguous. `wrEn` never drops mid-pixel.
- Sample encoding:
  - `pix_hit[k]`=0 → `data` = all-ones (invalid marker).
  - Hit with value all-ones → `data` = all-ones − 1, so a real hit is never dropped.
  - Otherwise `data` = the sample unchanged.
- Counters: pixel `0..PIXEL_NUM-1` and acquisition `0..ACQ_NUM-1`, each $clog2 width.
  - Pixel wraps to 0 after the last sample of pixel PIXEL_NUM-1; acquisition then increments.
  - Acquisition wraps to 0 at frame end.
- Frame end: `frame_done` pulses and `pass` toggles, both in the cycle after the last `wrEn`.

## Timing
- Reset values:
  - `wrEn`=0, `data`=0, `pass`=0, `frame_done`=0, `busy`=0.
  - `pix_ready`=0 while `res` is high; `pix_ready`=1 the first cycle after.
  - FIFO empty, all counters 0, FSM in IDLE.
- Latency: a word accepted at cycle N with FSM idle produces its first `wrEn` at N+2 (FIFO write N+1, load/emit N+2). The remaining samples follow at N+3..N+DATA_NUM+1.
- Throughput: back-to-back pixels give continuous `wrEn`, one pixel per DATA_NUM cycles. Frame boundaries add exactly IDLE_GAP low cycles.
- `data` is registered and changes only when `wrEn`=1. It holds its last value while `wrEn`=0.
- Reset mid-frame: FIFO is flushed, the partial pixel is discarded, counters go to 0, and `pass` goes to 0 in the next cycle.

## Test plan
Parameters for all scenarios: NP=16, DATA_NUM=4, PIXEL_NUM=3, ACQ_NUM=2, IDLE_GAP=4.

- Single pixel: push data {0x0010, 0x0020, 0x0030, 0x0040} with hit=4'b1111 at cycle N → `wrEn` high at N+2..N+5 with data 0x0010, 0x0020, 0x0030, 0x0040; `busy` falls afterwards.
- Encoding: hit=4'b0101 with data {0x1111, 0x2222, 0xFFFF, 0x3333} → output 0x1111, 0xFFFF, 0xFFFE, 0xFFFF.
- Full frame with `pix_valid` held high (6 pixels):
  - 24 contiguous `wrEn` cycles.
  - `frame_done` pulses once, the cycle after the 24th sample, and `pass` goes 0→1.
  - Exactly 4 `wrEn`-low cycles follow before the next frame's first sample.
  - A second frame returns `pass` to 0.
- Backpressure: hold the consumer path busy with `pix_valid`=1 → `pix_ready` drops after 2 buffered words; no word is lost or duplicated (scoreboard order check).
- Sparse input: gaps of 7 cycles between `pix_valid` pulses → each pixel's 4 samples are contiguous; `wrEn` is low only between pixels.
- Reset mid-pixel: assert `res` after the 2nd sample of pixel 1 → next cycle `wrEn`=0, `pass`=0, `pix_ready`=0 while in reset. After release, new input restarts at pixel 0, acquisition 0, and a full 24-sample frame completes.

Source files
------------

// File: rtl/tdc_stream_tx.sv
// Transmit side of the histogram-builder input stream: buffers pixel words from the
// TDC capture logic and serializes their timestamps in sample/pixel/acquisition order.
module tdc_stream_tx #(
    parameter int NP        = 16,
    parameter int DATA_NUM  = 4,
    parameter int PIXEL_NUM = 200,
    parameter int ACQ_NUM   = 33333,
    parameter int IDLE_GAP  = 4
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [DATA_NUM*NP-1:0] pix_data,
    input  logic [DATA_NUM-1:0]    pix_hit,
    output logic                   wrEn,
    output logic [NP-1:0]          data,
    output logic                   pass,
    output logic                   frame_done,
    output logic                   busy
);
    localparam int CW = $clog2(DATA_NUM);
    localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam int DW = DATA_NUM * NP;
    localparam int EW = DW + DATA_NUM;

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(DATA_NUM - 1);
    localparam logic [PW-1:0] PIXEL_LAST  = PW'(PIXEL_NUM - 1);
    localparam logic [AW-1:0] ACQ_LAST    = AW'(ACQ_NUM - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(IDLE_GAP - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    // Missing hits become all-ones; a real all-ones hit is nudged down so it still counts.
    function automatic logic [NP-1:0] encode_sample(input logic [NP-1:0] sample, input logic hit);
        logic [NP-1:0] ones;
        ones = {NP{1'b1}};
        if (!hit) begin
            encode_sample = ones;
        end else if (sample == ones) begin
            encode_sample = ones - {{(NP-1){1'b0}}, 1'b1};
        end else begin
            encode_sample = sample;
        end
    endfunction

    state_t          state_r, state_s;
    logic [EW-1:0]   fifo_mem_r [2];
    logic            wr_ptr_r, rd_ptr_r;
    logic [1:0]      count_r, count_s;
    logic            push_s, pop_s, emit_s, emit_hit_s, last_s;
    logic [NP-1:0]   emit_sample_s;
    logic [DW-1:0]   head_data_s, shift_data_r;
    logic [DATA_NUM-1:0] head_hit_s, shift_hit_r;
    logic [CW-1:0]   sample_cnt_r;
    logic [PW-1:0]   pixel_r;
    logic [AW-1:0]   acq_r;
    logic [GW-1:0]   gap_cnt_r;
    logic            wr_en_r, pass_r, frame_done_r, busy_r;
    logic [NP-1:0]   data_r;

    assign pix_ready   = ~res & (count_r != 2'd2);
    assign push_s      = pix_valid & pix_ready;
    assign head_data_s = fifo_mem_r[rd_ptr_r][DW-1:0];
    assign head_hit_s  = fifo_mem_r[rd_ptr_r][EW-1:DW];

    assign wrEn       = wr_en_r;
    assign data       = data_r;
    assign pass       = pass_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + 2'd1;
            2'b01:   count_s = count_r - 2'd1;
            default: count_s = count_r;
        endcase
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {pix_hit, pix_data};
        end
    end

    // FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and per-cycle emit/pop decisions; loading from IDLE emits sample 0 at once.
    always_comb begin
        state_s       = state_r;
        pop_s         = 1'b0;
        emit_s        = 1'b0;
        emit_sample_s = {NP{1'b0}};
        emit_hit_s    = 1'b0;
        last_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != 2'd0) begin
                    pop_s         = 1'b1;
                    emit_s        = 1'b1;
                    emit_sample_s = head_data_s[NP-1:0];
                    emit_hit_s    = head_hit_s[0];
                    state_s       = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                emit_s        = 1'b1;
                emit_sample_s = shift_data_r[NP-1:0];
                emit_hit_s    = shift_hit_r[0];
                if (sample_cnt_r == SAMPLE_LAST) begin
                    last_s = 1'b1;
                    if ((pixel_r == PIXEL_LAST) && (acq_r == ACQ_LAST)) begin
                        state_s = GAP;
                    end else if (count_r != 2'd0) begin
                        pop_s   = 1'b1;
                        state_s = SEND;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Shift register, output registers, and pixel/acquisition/gap bookkeeping.
    always_ff @(posedge clk) begin
        if (res) begin
            shift_data_r <= {DW{1'b0}};
            shift_hit_r  <= {DATA_NUM{1'b0}};
            sample_cnt_r <= {CW{1'b0}};
            pixel_r      <= {PW{1'b0}};
            acq_r        <= {AW{1'b0}};
            gap_cnt_r    <= {GW{1'b0}};
            wr_en_r      <= 1'b0;
            data_r       <= {NP{1'b0}};
            pass_r       <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            wr_en_r <= emit_s;
            if (emit_s) begin
                data_r <= encode_sample(emit_sample_s, emit_hit_s);
            end
            if (pop_s && (state_r == IDLE)) begin
                shift_data_r <= {{NP{1'b0}}, head_data_s[DW-1:NP]};
                shift_hit_r  <= {1'b0, head_hit_s[DATA_NUM-1:1]};
                sample_cnt_r <= CW'(1);
            end else if (pop_s) begin
                shift_data_r <= head_data_s;
                shift_hit_r  <= head_hit_s;
                sample_cnt_r <= {CW{1'b0}};
            end else if (emit_s) begin
                shift_data_r <= {{NP{1'b0}}, shift_data_r[DW-1:NP]};
                shift_hit_r  <= {1'b0, shift_hit_r[DATA_NUM-1:1]};
                sample_cnt_r <= last_s ? {CW{1'b0}} : sample_cnt_r + CW'(1);
            end
            if (last_s) begin
                if (pixel_r == PIXEL_LAST) begin
                    pixel_r <= {PW{1'b0}};
                    acq_r   <= (acq_r == ACQ_LAST) ? {AW{1'b0}} : acq_r + AW'(1);
                end else begin
                    pixel_r <= pixel_r + PW'(1);
                end
            end
            if (state_r == GAP) begin
                gap_cnt_r <= (gap_cnt_r == GAP_LAST) ? {GW{1'b0}} : gap_cnt_r + GW'(1);
            end else begin
                gap_cnt_r <= {GW{1'b0}};
            end
            // First GAP cycle is the cycle after the frame's last sample.
            frame_done_r <= (state_r == GAP) && (gap_cnt_r == {GW{1'b0}});
            if ((state_r == GAP) && (gap_cnt_r == {GW{1'b0}})) begin
                pass_r <= ~pass_r;
            end
            busy_r <= (count_s != 2'd0) || (state_s != IDLE) || emit_s;
        end
    end
endmodule

// File: tb/tb_tdc_stream_tx.sv
// Directed bench for tdc_stream_tx with 3 pixels x 2 acquisitions per frame.
module tb_tdc_stream_tx;
    logic        clk = 1'b0;
    logic        res;
    logic        pix_valid;
    logic        pix_ready;
    logic [63:0] pix_data;
    logic [3:0]  pix_hit;
    logic        wrEn;
    logic [15:0] data;
    logic        pass;
    logic        frame_done;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int gw = 0;

    int          hi_runs[$];
    int          lo_runs[$];
    logic        fd_pass[$];
    logic [15:0] exp_q[$];
    int          n_wr, n_fd, fd_bad, sb_err, contig_err, pass_bad, timed_out;
    logic [5:0]  ready_trace;
    int          seen;

    tdc_stream_tx #(.NP(16), .DATA_NUM(4), .PIXEL_NUM(3), .ACQ_NUM(2), .IDLE_GAP(4)) dut (
        .clk(clk), .res(res), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_hit(pix_hit), .wrEn(wrEn), .data(data),
        .pass(pass), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the next unique word (all hits) and return its four samples.
    task automatic drive_word(output logic [15:0] s [4]);
        for (int k = 0; k < 4; k++) begin
            s[k] = 16'(gw * 256 + k + 17);
            pix_data[k*16 +: 16] = s[k];
        end
        pix_hit = 4'hF;
        gw++;
    endtask

    task automatic run(input int n_words, input int gap, input int budget);
        int idx, gap_left, cyc, idle_after, hi_len, lo_len;
        bit acc, seen_hi, prev_wr, prev_pass;
        logic [15:0] s [4];
        logic [15:0] exp_v;
        hi_runs.delete(); lo_runs.delete(); fd_pass.delete(); exp_q.delete();
        n_wr = 0; n_fd = 0; fd_bad = 0; sb_err = 0; contig_err = 0; pass_bad = 0;
        timed_out = 0; ready_trace = 6'b0;
        idx = 0; gap_left = 0; cyc = 0; idle_after = 0; hi_len = 0; lo_len = 0;
        acc = 0; seen_hi = 0; prev_wr = 0; prev_pass = pass;
        while (idle_after < 8) begin
            @(negedge clk);
            if (wrEn) begin
                if (exp_q.size() == 0) begin
                    sb_err++;
                end else begin
                    exp_v = exp_q.pop_front();
                    if (data !== exp_v) sb_err++;
                end
                n_wr++;
                if (!prev_wr && seen_hi) lo_runs.push_back(lo_len);
                hi_len++;
                seen_hi = 1;
                lo_len = 0;
            end else begin
                if (prev_wr) begin
                    hi_runs.push_back(hi_len);
                    if (hi_len % 4 != 0) contig_err++;
                    hi_len = 0;
                end
                lo_len++;
            end
            if (frame_done) begin
                n_fd++;
                fd_pass.push_back(pass);
                if (!(prev_wr && !wrEn)) fd_bad++;
            end
            if ((pass !== prev_pass) && !frame_done) pass_bad++;
            prev_pass = pass;
            prev_wr = wrEn;
            if (cyc < 6) ready_trace[cyc] = pix_ready;
            if (acc) begin
                idx++;
                gap_left = gap;
            end
            if (idx < n_words && gap_left == 0) begin
                pix_valid = 1'b1;
                drive_word(s);
                gw--;
            end else begin
                pix_valid = 1'b0;
                if (gap_left > 0) gap_left--;
            end
            acc = pix_valid && pix_ready;
            if (acc) begin
                gw++;
                for (int k = 0; k < 4; k++) exp_q.push_back(s[k]);
            end
            if (idx >= n_words && exp_q.size() == 0 && !wrEn) idle_after++;
            cyc++;
            if (cyc > budget) begin
                timed_out = 1;
                break;
            end
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] s [4];
        res = 1'b1; pix_valid = 1'b0; pix_data = 64'h0; pix_hit = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_wrEn", wrEn, 0);
        check("rst_data", data, 0);
        check("rst_pass", pass, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        res = 1'b0;
        @(negedge clk);
        check("post_rst_pix_ready", pix_ready, 1);

        // Single pixel: first sample two cycles after acceptance.
        pix_valid = 1'b1; pix_hit = 4'hF;
        pix_data = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        @(negedge clk);
        pix_valid = 1'b0;
        check("single_lat_wrEn", wrEn, 0);
        check("single_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("single_wrEn", wrEn, 1);
            check("single_data", data, 32'(16'h0010 * (k + 1)));
        end
        @(negedge clk);
        check("single_end_wrEn", wrEn, 0);
        check("single_end_busy", busy, 0);
        check("single_hold_data", data, 32'h0040);

        // Encoding of misses and all-ones hits.
        pix_valid = 1'b1; pix_hit = 4'b0101;
        pix_data = {16'h3333, 16'hFFFF, 16'h2222, 16'h1111};
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        check("enc_s0", {wrEn, data}, {1'b1, 16'h1111});
        @(negedge clk);
        check("enc_s1", {wrEn, data}, {1'b1, 16'hFFFF});
        @(negedge clk);
        check("enc_s2", {wrEn, data}, {1'b1, 16'hFFFE});
        @(negedge clk);
        check("enc_s3", {wrEn, data}, {1'b1, 16'hFFFF});

        res = 1'b1;
        @(negedge clk);
        res = 1'b0;

        // Two full frames with pix_valid held high.
        run(12, 0, 300);
        check("frame_timeout", timed_out, 0);
        check("bp_ready_trace", ready_trace, 6'b100111);
        check("frame_hi_count", hi_runs.size(), 2);
        check("frame1_len", hi_runs[0], 24);
        check("frame2_len", hi_runs[1], 24);
        check("frame_lo_count", lo_runs.size(), 1);
        check("frame_gap_len", lo_runs[0], 4);
        check("frame_fd_count", n_fd, 2);
        check("frame_fd_timing", fd_bad, 0);
        check("frame1_pass", fd_pass[0], 1);
        check("frame2_pass", fd_pass[1], 0);
        check("frame_pass_stable", pass_bad, 0);
        check("frame_scoreboard", sb_err, 0);
        check("frame_n_wr", n_wr, 48);
        check("frame_end_busy", busy, 0);

        // Sparse input: 7 idle cycles between words.
        run(3, 7, 300);
        check("sparse_timeout", timed_out, 0);
        check("sparse_hi_count", hi_runs.size(), 3);
        check("sparse_contig", contig_err, 0);
        check("sparse_lo", lo_runs[0], 4);
        check("sparse_scoreboard", sb_err, 0);
        check("sparse_n_wr", n_wr, 12);
        check("sparse_fd", n_fd, 0);

        // Finish that frame so pass becomes 1.
        run(3, 0, 200);
        check("finish_fd", n_fd, 1);
        check("finish_pass", pass, 1);
        check("finish_scoreboard", sb_err, 0);

        // Reset after the second sample of pixel 1.
        @(negedge clk);
        pix_valid = 1'b1;
        drive_word(s);
        @(negedge clk);
        drive_word(s);
        @(negedge clk);
        pix_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (wrEn) seen++;
            if (seen == 6) break;
            @(negedge clk);
        end
        check("rstmid_reached", seen, 6);
        res = 1'b1;
        @(negedge clk);
        check("rstmid_wrEn", wrEn, 0);
        check("rstmid_pass", pass, 0);
        check("rstmid_ready", pix_ready, 0);
        check("rstmid_busy", busy, 0);
        res = 1'b0;
        run(6, 0, 300);
        check("rstmid_timeout", timed_out, 0);
        check("rstmid_hi_count", hi_runs.size(), 1);
        check("rstmid_frame_len", hi_runs[0], 24);
        check("rstmid_fd", n_fd, 1);
        check("rstmid_fd_pass", fd_pass[0], 1);
        check("rstmid_scoreboard", sb_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
